// File: rtl/mac_vec_engine_if.sv
// Host-side bus of mac_vec_engine: FIFO load strobes, run control, status and results.
// The master modport drives the host side and the slave modport is used by the engine.
interface mac_vec_engine_if #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned VEC_LEN = 8
);
  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(VEC_LEN) + 1;
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                    a_wr;
  logic [RowW-1:0]         a_row;
  logic [DATA_W-1:0]       a_data;
  logic                    b_wr;
  logic [DATA_W-1:0]       b_data;
  logic                    start;
  logic                    clr;
  logic [ROWS-1:0]         a_full;
  logic                    b_full;
  logic                    ready;
  logic                    busy;
  logic                    done;
  logic                    start_err;
  logic [ROWS*ACC_W-1:0]   c_out;

  modport master (
    output a_wr, a_row, a_data, b_wr, b_data, start, clr,
    input  a_full, b_full, ready, busy, done, start_err, c_out
  );

  modport slave (
    input  a_wr, a_row, a_data, b_wr, b_data, start, clr,
    output a_full, b_full, ready, busy, done, start_err, c_out
  );
endinterface

// File: rtl/mac_vec_engine.sv
// Matrix-vector MAC engine: ROWS A-row FIFOs and one shared B FIFO feed ROWS accumulating
// lanes; each run consumes VEC_LEN entries from every FIFO and holds the dot products.
// Optional feature: define MAC_SIGNED_EN for two's-complement operands and results.
module mac_vec_engine #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned VEC_LEN = 8
) (
  input logic             clk,
  input logic             rst_n,
  mac_vec_engine_if.slave bus
);
  localparam int unsigned ACC_W   = 2 * DATA_W + $clog2(VEC_LEN) + 1;
  localparam int unsigned ProdW   = 2 * DATA_W;
  localparam int unsigned NumFifo = ROWS + 1;  // index ROWS is the B FIFO
  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned LenW    = $clog2(VEC_LEN + 1);
  localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [LenW-1:0]   cnt_q, cnt_d;
  logic              pop, accept, reject;
  logic              start_err_q;
  logic              all_ready;

  logic [NumFifo-1:0] wr_en;
  logic [NumFifo-1:0] full;
  logic [DATA_W-1:0]  wr_data  [NumFifo];
  logic [DATA_W-1:0]  mem_q    [NumFifo][DEPTH];
  logic [PtrW-1:0]    wr_ptr_q [NumFifo];
  logic [PtrW-1:0]    rd_ptr_q [NumFifo];
  logic [CntW-1:0]    count_q  [NumFifo];
  logic [DATA_W-1:0]  rd_q     [NumFifo];

  logic               mac_en_q;
  logic [ProdW-1:0]   mul   [ROWS];
  logic [ACC_W-1:0]   prod  [ROWS];
  logic [ACC_W-1:0]   acc_q [ROWS];

  // FIFO flags, write decode and run readiness; clr suppresses any same-cycle write.
  always_comb begin
    all_ready = 1'b1;
    for (int f = 0; f < NumFifo; f++) begin
      full[f] = (count_q[f] == CntW'(DEPTH));
      if (count_q[f] < CntW'(VEC_LEN)) all_ready = 1'b0;
      if (f < ROWS) begin
        wr_data[f] = bus.a_data;
        wr_en[f]   = bus.a_wr && (bus.a_row == RowW'(f)) && !full[f] && !bus.clr;
      end else begin
        wr_data[f] = bus.b_data;
        wr_en[f]   = bus.b_wr && !full[f] && !bus.clr;
      end
    end
  end

  // Next-state logic: run acceptance, pop sequencing and pipeline drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          if (all_ready) begin
            accept  = 1'b1;
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      StRun: begin
        pop = 1'b1;
        if (cnt_q == LenW'(VEC_LEN - 1)) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LenW'(1);
        end
      end
      StFlush: begin
        // Two cycles: one for the registered FIFO read, one for the last accumulate.
        if (cnt_q == LenW'(1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LenW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.clr) begin
      state_d = StIdle;
      cnt_d   = '0;
      pop     = 1'b0;
      accept  = 1'b0;
      reject  = 1'b0;
    end
  end

  // FSM state, sequencing counter and the registered start_err pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_err_q <= reject;
    end
  end

  // FIFO pointers and occupancy; a simultaneous write and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      for (int f = 0; f < NumFifo; f++) begin
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        count_q[f]  <= '0;
      end
    end else begin
      for (int f = 0; f < NumFifo; f++) begin
        if (wr_en[f]) wr_ptr_q[f] <= wr_ptr_q[f] + PtrW'(1);
        if (pop)      rd_ptr_q[f] <= rd_ptr_q[f] + PtrW'(1);
        case ({wr_en[f], pop})
          2'b10:   count_q[f] <= count_q[f] + CntW'(1);
          2'b01:   count_q[f] <= count_q[f] - CntW'(1);
          default: count_q[f] <= count_q[f];
        endcase
      end
    end
  end

  // FIFO storage and registered read port; contents need no reset since counts gate use.
  always_ff @(posedge clk) begin
    for (int f = 0; f < NumFifo; f++) begin
      if (wr_en[f]) mem_q[f][wr_ptr_q[f]] <= wr_data[f];
      if (pop)      rd_q[f] <= mem_q[f][rd_ptr_q[f]];
    end
  end

`ifdef MAC_SIGNED_EN
  // Lane products, sign-extended to the accumulator width.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      mul[r]  = $signed(ProdW'($signed(rd_q[r]))) * $signed(ProdW'($signed(rd_q[ROWS])));
      prod[r] = {{(ACC_W - ProdW){mul[r][ProdW-1]}}, mul[r]};
    end
  end
`else
  // Lane products, zero-extended to the accumulator width.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      mul[r]  = ProdW'(rd_q[r]) * ProdW'(rd_q[ROWS]);
      prod[r] = {{(ACC_W - ProdW){1'b0}}, mul[r]};
    end
  end
`endif

  // Accumulators: cleared on reset, clr or an accepted start; accumulate one cycle after a pop.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr || accept) begin
      mac_en_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
    end else begin
      mac_en_q <= pop;
      if (mac_en_q) begin
        for (int r = 0; r < ROWS; r++) acc_q[r] <= acc_q[r] + prod[r];
      end
    end
  end

  // Status and result outputs.
  always_comb begin
    bus.c_out = '0;
    for (int r = 0; r < ROWS; r++) bus.c_out[r*ACC_W +: ACC_W] = acc_q[r];
    bus.a_full    = full[ROWS-1:0];
    bus.b_full    = full[ROWS];
    bus.ready     = all_ready;
    bus.busy      = (state_q == StRun) || (state_q == StFlush);
    bus.done      = (state_q == StDone);
    bus.start_err = start_err_q;
  end
endmodule

// File: doc/mac_vec_engine.md
# mac_vec_engine

Parametrised matrix-vector multiply engine: ROWS independent A-row FIFOs plus one shared B-vector FIFO feed a column of ROWS multiply-accumulate lanes. Each lane computes one dot product of length VEC_LEN. The block is the generalised successor to the fixed 8x8 FIFO-fed MAC array. It sits between the host load path and the result-collection logic, and adds FSM-controlled runs, readiness checking and held results.

## Interface
- ROWS, 8: number of A FIFOs and MAC lanes (≥1).
- DATA_W, 8: element width for A and B.
- DEPTH, 16: entries per FIFO; power of two, ≥ VEC_LEN.
- VEC_LEN, 8: elements consumed per FIFO per run (≥1).
- ACC_W, derived localparam: 2*DATA_W + $clog2(VEC_LEN) + 1.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- a_wr  in  1  write strobe for an A FIFO.
- a_row  in  $clog2(ROWS)  selects the target A FIFO; ignored if ≥ ROWS.
- a_data  in  DATA_W  A element.
- b_wr  in  1  write strobe for the B FIFO.
- b_data  in  DATA_W  B element.
- start  in  1  single-cycle run request.
- clr  in  1  abort or clear; flushes FIFOs and accumulators.
- a_full  out  ROWS  per-FIFO full flags.
- b_full  out  1  B FIFO full flag.
- ready  out  1  every FIFO holds ≥ VEC_LEN entries.
- busy  out  1  run in progress.
- done  out  1  results valid; level output.
- start_err  out  1  one-cycle pulse when a start is rejected.
- c_out  out  ROWS*ACC_W  lane r occupies bits [r*ACC_W +: ACC_W].

## Operation
**FIFOs**
- Synchronous FIFO with an occupancy count.
- A write to a full FIFO is dropped. Its contents and count are unchanged.
- A write and a pop in the same cycle are both honoured and the count is unchanged.

**FSM**
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE → RUN: on start with ready=1. All accumulators clear to 0, the pop counter is set to 0, and done drops.
- IDLE/DONE with start and ready=0: the block stays in its current state, pulses start_err, and leaves results untouched.
- RUN: each cycle pops one entry from every A FIFO and from the B FIFO at the same time. B is broadcast to all lanes. After VEC_LEN pops the FSM moves to FLUSH.
- FLUSH: waits 2 cycles for the read/MAC pipeline to drain, then moves to DONE.
- DONE: done=1 and c_out holds steady until the next accepted start, clr, or reset.
- start while busy=1 is ignored and does not pulse start_err.

**clr**
- Takes effect from any state: the FSM goes to IDLE, all FIFOs empty, accumulators go to 0, done goes to 0.
- clr wins over start and over a write in the same cycle.

**Host writes**
- Writes are legal in every state, including RUN. This lets the host preload the next run.

**Arithmetic**
- Lane r: acc_r += A_r[k] * B[k], for k = 0..VEC_LEN-1.
- Unsigned by default.
- ACC_W guarantees no overflow, so no wrap or saturation logic is needed.

## Timing
**Reset** (rst_n=0 at a clock edge):
- FSM goes to IDLE and every FIFO empties.
- a_full=0, b_full=0, ready=0, busy=0, done=0, start_err=0, c_out=0.
- Reset mid-run discards all state.

**Write-to-flag latency**
- An accepted write updates the count, full flags and ready on the next cycle.

**Run latency** (start accepted at cycle t)
- busy=1 on cycles t+1 .. t+VEC_LEN+2.
- Pops occur on cycles t+1 .. t+VEC_LEN.
- FIFO read data is registered (1 cycle). The multiply-accumulate is registered (1 cycle).
- done=1 and final c_out from cycle t+VEC_LEN+3.
- A back-to-back start in DONE is accepted on the same cycle it is seen.

**start_err**
- Asserted in the cycle after the rejected start, for exactly 1 cycle.

**Other boundaries**
- VEC_LEN = DEPTH: a full FIFO drains to empty during the run.
- With a simultaneous write in the last pop cycle, the FIFO ends at count 1.

## Configuration
- MAC_SIGNED_EN defined: A and B are two's-complement. Products and accumulators are sign-extended and c_out is signed.
- MAC_SIGNED_EN undefined: all operands and results are unsigned.
- ACC_W is identical in both builds.

## Test plan
- Defaults. Load A row r with 8 × (r+1) and B with 8 × 2, then start → done at t+11; c_out lane r = 16*(r+1); busy high for 10 cycles.
- Max values. All A = 255, all B = 255 (unsigned) → every lane = 520200. With MAC_SIGNED_EN: all -128 → every lane = 131072, and all A = -128 with B = 127 → every lane = -130048.
- Only 7 entries in A row 3, then start → start_err pulses 1 cycle, state stays IDLE, c_out unchanged; the 8th write raises ready.
- Fill row 0 to 16 entries, write a 17th value 0xAA → write dropped; a_full[0]=1; a 2-run sequence never returns 0xAA.
- Assert clr at cycle t+4 of a run → next cycle: busy=0, done=0, c_out=0, all FIFOs empty, ready=0.
- Preload run 2 during run 1 RUN cycles, then start in DONE → run 2 accepted immediately, done drops for 10 cycles, and run 2 results are correct.
